msk_and_hpc3_vec: RTL and testbench
===================================

MSK_AND_HPC3_VEC -- requirements
Module: msk_and_hpc3_vec

Interface
- REQ-001: Parameter d, default 2: number of shares, d >= 2.
- REQ-002: Parameter W, default 4: number of independent AND lanes, W >= 1.
- REQ-003: Parameter P, default 0: extra output pipeline stages, 0..4.
- REQ-004: Parameter SWAP, default 0: when 1, operand roles are exchanged (a<->b) in every lane.
- REQ-005: Derived constant R = d*(d-1) random bits per lane; RT = W*R in total.
- REQ-006: clk  in  1: single clock; all registers update on its rising edge.
- REQ-007: rst_n  in  1: asynchronous, active-low reset.
- REQ-008: en  in  1: global advance; when 0 every register holds its value.
- REQ-009: in_valid  in  1: ina/inb carry a new operation this cycle.
- REQ-010: ina  in  d*W: sharing of operand a; lane l, share i at bit i*W+l.
- REQ-011: inb  in  d*W: sharing of operand b; same layout as ina.
- REQ-012: rnd  in  RT: fresh randomness, valid in the same cycle as in_valid.
- REQ-013: rnd_valid  in  1: rnd is fresh this cycle.
- REQ-014: rnd_req  out  1: combinational, = in_valid & en.
- REQ-015: out  out  d*W: sharing of a&b per lane; same layout as ina.
- REQ-016: out_valid  out  1: out holds a completed operation.
- REQ-017: rnd_err  out  1: sticky flag, set when in_valid & en & ~rnd_valid.

Function
- REQ-018: Pair index p enumerates (i,j), i<j, lexicographically. For lane l, r_ij = r_ji = rnd[l*R+2p] and s_ij = s_ji = rnd[l*R+2p+1].
- REQ-019: Per lane, with x = a, y = b when SWAP=0 and x = b, y = a when SWAP=1, stage-1 registers SHALL be:
  - D_i = reg(x_i & y_i);
  - U_ij = reg((x_i & (y_j ^ r_ij)) ^ s_ij) for j != i;
  - V_ij = reg((~x_i & r_ij) ^ s_ij) for j != i.
- REQ-020: Share c_i = D_i ^ XOR over j != i of (U_ij ^ V_ij). The XOR SHALL be formed only from register outputs; no cross-domain logic precedes a register.
- REQ-021: Correctness: XOR_i c_i = (XOR_i a_i) & (XOR_i b_i) per lane, for every value of rnd.
- REQ-022: Latency: out presents c exactly 1+P advancing (en=1) cycles after capture.
- REQ-023: The P extra stages are plain registers on c; they carry no recombination.
- REQ-024: Capture condition cap = en & in_valid & rnd_valid. The stage-1 data registers load on every en=1 cycle regardless of cap.
- REQ-025: A valid shift chain of depth 1+P loads cap at its head on each en=1 cycle; out_valid is the tail of this chain.
- REQ-026: in_valid & en & ~rnd_valid: the operation is dropped (its valid bit is 0), rnd_err is set and remains 1 until reset.
- REQ-027: en=0: the data registers, the valid chain and rnd_err hold; rnd_req=0; inputs are ignored.
- REQ-028: Back-to-back operations with en=1 SHALL be accepted every cycle (throughput 1/cycle).
- REQ-029: With W>1, lanes are fully independent; lane l output depends only on lane l shares and lane l rnd bits.
- REQ-030: SWAP changes only which operand is masked by r. Output correctness (REQ-021) and latency are unchanged.

Reset
- REQ-031: rst_n=0 asynchronously clears all data registers, the valid chain and rnd_err to 0. out=0 and out_valid=0 while rst_n=0.
- REQ-032: Reset asserted mid-pipeline discards in-flight operations. No out_valid follows release for them.
- REQ-033: First capture is possible on the first rising edge with rst_n=1.

Verification
- REQ-034: d=2, W=4, P=0. Apply a=0b1011 and b=0b0110 (unmasked), with random shares and random rnd. -> One cycle later out_valid=1 and the XOR of out shares = 0b0010.
- REQ-035: d=3, W=1, P=2, SWAP=1. Exhaustively sweep a,b in {0,1} with all share splits and 1000 random rnd values. -> Output XOR = a&b each time, exactly 3 cycles after capture.
- REQ-036: Stream 8 back-to-back valid operations, with en=0 for 2 cycles in the middle. -> 8 results in order, delayed by exactly 2 cycles, with no duplicates or losses.
- REQ-037: in_valid=1, rnd_valid=0 for one cycle. -> No out_valid for that operation; rnd_err=1 thereafter until rst_n=0.
- REQ-038: Assert rst_n=0 for one cycle while 2 operations are in flight (P=2). -> out=0 and out_valid=0 immediately; no out_valid pulse after release.
- REQ-039: Fix the inputs and vary only rnd across cycles. -> Individual out shares change, while the output XOR stays constant.

Source files
------------

// File: rtl/msk_and_hpc3_vec.sv
`default_nettype none
// ============================================================================
//  Module   : msk_and_hpc3_vec
//  Purpose  : W-lane, d-share masked AND gadget (HPC3 style). It has one
//             register stage before share recombination, then P plain
//             output registers.
//  Revision : 1.0  initial release
// ============================================================================
module msk_and_hpc3_vec #(
    parameter  int d    = 2,
    parameter  int W    = 4,
    parameter  int P    = 0,
    parameter  int SWAP = 0,
    localparam int R    = d * (d - 1),
    localparam int RT   = W * R
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [d*W-1:0]   ina,
    input  logic [d*W-1:0]   inb,
    input  logic [RT-1:0]    rnd,
    input  logic             rnd_valid,
    output logic             rnd_req,
    output logic [d*W-1:0]   out,
    output logic             out_valid,
    output logic             rnd_err
);

    // Lexicographic index of the share pair (i,j), i<j
    function automatic int f_pair(input int i, input int j);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    logic [d-1:0][W-1:0]         w_x;
    logic [d-1:0][W-1:0]         w_y;
    logic [W-1:0][d-1:0][d-1:0]  w_u;
    logic [W-1:0][d-1:0][d-1:0]  w_v;
    logic [W-1:0][d-1:0][d-1:0]  r_u;
    logic [W-1:0][d-1:0][d-1:0]  r_v;
    logic [d-1:0][W-1:0]         r_d;
    logic [d-1:0][W-1:0]         w_c;
    logic [P:0]                  r_vld;
    logic                        r_err;
    logic                        w_cap;

    generate
        if (SWAP != 0) begin : g_swap
            assign w_x = inb;
            assign w_y = ina;
        end else begin : g_noswap
            assign w_x = ina;
            assign w_y = inb;
        end
    endgenerate

    // Cross-domain terms; the diagonal carries no term and is tied to zero
    generate
        for (genvar l = 0; l < W; l++) begin : g_lane
            for (genvar i = 0; i < d; i++) begin : g_share
                for (genvar j = 0; j < d; j++) begin : g_pair
                    if (i != j) begin : g_cross
                        localparam int c_PAIR = (i < j) ? f_pair(i, j) : f_pair(j, i);
                        localparam int c_RBIT = l * R + 2 * c_PAIR;
                        assign w_u[l][i][j] = (w_x[i][l] & (w_y[j][l] ^ rnd[c_RBIT]))
                                              ^ rnd[c_RBIT+1];
                        assign w_v[l][i][j] = (~w_x[i][l] & rnd[c_RBIT]) ^ rnd[c_RBIT+1];
                    end else begin : g_diag
                        assign w_u[l][i][j] = 1'b0;
                        assign w_v[l][i][j] = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign w_cap   = en & in_valid & rnd_valid;
    assign rnd_req = in_valid & en;

    // Stage-1 registers load on every advance; validity travels separately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= '0;
            r_u <= '0;
            r_v <= '0;
        end else if (en) begin
            r_d <= w_x & w_y;
            r_u <= w_u;
            r_v <= w_v;
        end
    end

    // Recombination uses register outputs only
    always_comb begin
        w_c = '0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                w_c[i][l] = r_d[i][l] ^ (^(r_u[l][i] ^ r_v[l][i]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (en) begin
            r_vld[0] <= w_cap;
            for (int k = 1; k <= P; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (en && in_valid && !rnd_valid) begin
            r_err <= 1'b1;
        end
    end

    generate
        if (P > 0) begin : g_pipe
            logic [P-1:0][d*W-1:0] r_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else if (en) begin
                    r_pipe[0] <= w_c;
                    for (int k = 1; k < P; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign out = r_pipe[P-1];
        end else begin : g_nopipe
            assign out = w_c;
        end
    endgenerate

    assign out_valid = r_vld[P];
    assign rnd_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_msk_and_hpc3_vec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msk_and_hpc3_vec
//  Purpose  : Self-checking bench for msk_and_hpc3_vec, with two
//             configurations checked against an unmasked scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_msk_and_hpc3_vec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, in_valid, rnd_valid;
    // Instance A: d=2, W=4, P=0, SWAP=0
    logic [7:0] a_ina, a_inb, a_rnd, a_out;
    logic       a_req, a_ov, a_err;
    // Instance B: d=3, W=1, P=2, SWAP=1
    logic [2:0] b_ina, b_inb, b_out;
    logic [5:0] b_rnd;
    logic       b_req, b_ov, b_err;

    msk_and_hpc3_vec #(.d(2), .W(4), .P(0), .SWAP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .ina(a_ina), .inb(a_inb), .rnd(a_rnd), .rnd_valid(rnd_valid),
        .rnd_req(a_req), .out(a_out), .out_valid(a_ov), .rnd_err(a_err)
    );

    msk_and_hpc3_vec #(.d(3), .W(1), .P(2), .SWAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .ina(b_ina), .inb(b_inb), .rnd(b_rnd), .rnd_valid(rnd_valid),
        .rnd_req(b_req), .out(b_out), .out_valid(b_ov), .rnd_err(b_err)
    );

    // Scoreboard entry: advancing-edge number of capture and the plain a&b
    typedef struct {
        int         idx;
        logic [3:0] v;
    } op_t;

    op_t        qa[$];
    op_t        qb[$];
    int         n;
    logic       m_err;
    int         tests;
    int         fails;
    int         b_seen;
    logic [3:0] a_pa, a_pb;
    logic       b_pa, b_pb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain operands are the reference; shares and rnd are random
    task automatic set_ops(input logic [3:0] pa_a, input logic [3:0] pb_a,
                           input logic pa_b, input logic pb_b);
        logic [3:0] s;
        logic [1:0] t;
        a_pa  = pa_a;
        a_pb  = pb_a;
        b_pa  = pa_b;
        b_pb  = pb_b;
        s     = 4'($urandom);
        a_ina = {s, pa_a ^ s};
        s     = 4'($urandom);
        a_inb = {s, pb_a ^ s};
        t     = 2'($urandom);
        b_ina = {t, pa_b ^ (^t)};
        t     = 2'($urandom);
        b_inb = {t, pb_b ^ (^t)};
        a_rnd = 8'($urandom);
        b_rnd = 6'($urandom);
    endtask

    task automatic check_outputs();
        logic ev_a, ev_b;
        while (qa.size() > 0 && qa[0].idx < n) void'(qa.pop_front());
        while (qb.size() > 0 && qb[0].idx + 2 < n) void'(qb.pop_front());
        ev_a = (qa.size() > 0) && (qa[0].idx == n);
        ev_b = (qb.size() > 0) && (qb[0].idx + 2 == n);
        chk("a_out_valid", 32'(a_ov), 32'(ev_a));
        if (ev_a) chk("a_xor", 32'(a_out[3:0] ^ a_out[7:4]), 32'(qa[0].v));
        chk("b_out_valid", 32'(b_ov), 32'(ev_b));
        if (ev_b) chk("b_xor", 32'(^b_out), 32'(qb[0].v[0]));
        chk("a_rnd_err", 32'(a_err), 32'(m_err));
        chk("b_rnd_err", 32'(b_err), 32'(m_err));
    endtask

    task automatic tick();
        logic cap, adv, bad;
        logic [3:0] va;
        logic vb;
        op_t e;
        @(negedge clk);
        chk("a_rnd_req", 32'(a_req), 32'(in_valid & en));
        chk("b_rnd_req", 32'(b_req), 32'(in_valid & en));
        adv = en;
        cap = en & in_valid & rnd_valid;
        bad = en & in_valid & ~rnd_valid;
        va  = a_pa & a_pb;
        vb  = b_pa & b_pb;
        @(posedge clk);
        #1;
        if (adv) begin
            n++;
            if (cap) begin
                e.idx = n; e.v = va;          qa.push_back(e);
                e.idx = n; e.v = {3'b000, vb}; qb.push_back(e);
            end
        end
        if (bad) m_err = 1'b1;
        if (adv && b_ov) b_seen++;
        check_outputs();
    endtask

    // Called 1 time unit after a rising edge; checks outputs during reset
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_a_out", 32'(a_out), 32'h0);
        chk("rst_a_valid", 32'(a_ov), 32'h0);
        chk("rst_a_err", 32'(a_err), 32'h0);
        chk("rst_b_out", 32'(b_out), 32'h0);
        chk("rst_b_valid", 32'(b_ov), 32'h0);
        chk("rst_b_err", 32'(b_err), 32'h0);
        qa.delete();
        qb.delete();
        n     = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] c;
        logic [7:0] prev;
        logic       changed;
        tests = 0; fails = 0; n = 0; m_err = 1'b0; b_seen = 0;
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        a_ina = '0; a_inb = '0; a_rnd = '0; b_ina = '0; b_inb = '0; b_rnd = '0;
        a_pa = '0; a_pb = '0; b_pa = 1'b0; b_pb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // First edge after release captures; known operands on the 4-lane instance
        en = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1;
        set_ops(4'b1011, 4'b0110, 1'b1, 1'b1);
        tick();
        chk("first_valid", 32'(a_ov), 32'h1);
        chk("first_xor", 32'(a_out[3:0] ^ a_out[7:4]), 32'h2);

        // Every operand value and share split on the 3-share instance
        for (int it = 0; it < 1000; it++) begin
            c = 6'(it % 64);
            set_ops(4'($urandom), 4'($urandom), c[0], c[1]);
            b_ina = {c[3:2], c[0] ^ (^c[3:2])};
            b_inb = {c[5:4], c[1] ^ (^c[5:4])};
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Eight back-to-back operations with a two-cycle stall in the middle
        b_seen = 0;
        for (int k = 0; k < 10; k++) begin
            en = !(k == 4 || k == 5);
            in_valid = 1'b1;
            set_ops(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        en = 1'b1; in_valid = 1'b0;
        repeat (4) tick();
        chk("stream_count", 32'(b_seen), 32'd8);

        // Random enable and valid mix
        for (int k = 0; k < 300; k++) begin
            en = ($urandom_range(0, 3) != 0);
            in_valid = 1'($urandom);
            set_ops(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        // Fixed operands, fresh randomness only
        en = 1'b1; in_valid = 1'b1;
        set_ops(4'b1101, 4'b0111, 1'b1, 1'b1);
        tick();
        prev = a_out; changed = 1'b0;
        for (int k = 0; k < 20; k++) begin
            a_rnd = 8'($urandom);
            b_rnd = 6'($urandom);
            tick();
            if (a_out !== prev) changed = 1'b1;
            prev = a_out;
        end
        chk("share_refresh", 32'(changed), 32'h1);

        // Missing randomness drops the operation and sets the sticky flag
        in_valid = 1'b1; rnd_valid = 1'b0;
        set_ops(4'($urandom), 4'($urandom), 1'b1, 1'b1);
        tick();
        rnd_valid = 1'b1; in_valid = 1'b0;
        repeat (3) tick();
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        tick();
        chk("err_sticky", 32'(b_err), 32'h1);

        // Reset with two operations in flight in the deeper pipeline
        do_reset();
        in_valid = 1'b1;
        set_ops(4'($urandom), 4'($urandom), 1'b1, 1'b1);
        tick();
        set_ops(4'($urandom), 4'($urandom), 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        do_reset();
        b_seen = 0;
        repeat (5) tick();
        chk("no_ghost", 32'(b_seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
